// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller.
// Owns the fetch PC, captures instruction words into a 2-entry FIFO and
// hands {pc, instr} pairs to decode over a valid/ready handshake.
// Optional build macro: FETCH_ALIGN_CHECK_EN.
// Defined: misaligned or out-of-range redirect targets enter a sticky FAULT state.
// Undefined: the low two target bits are masked, out-of-range targets halt, and fault stays 0.
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] LastPc = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALT,
        FAULT
    } state_t;

    state_t      r_state;
    logic [31:0] r_fpc;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_qPc    [2];
    logic [31:0] r_qInstr [2];
    logic        r_halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        r_fault;
`endif

    logic        w_pop;
    logic        w_push;
    logic        w_tail;
    logic [1:0]  w_countNext;
    logic        w_redirect;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        w_redirBad;
`else
    logic [31:0] w_redirPc;
    logic        w_redirHigh;
`endif

    // Handshake, fill and redirect-target decisions for the current cycle
    always_comb begin
        w_pop       = (r_count != 2'd0) && out_ready;
        w_push      = (r_state == FETCH) && (r_fpc <= LastPc) &&
                      ((r_count != 2'd2) || w_pop);
        w_tail      = r_head ^ r_count[0];
        w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_redirect  = redirect && (r_state != FAULT);
`ifdef FETCH_ALIGN_CHECK_EN
        w_redirBad  = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LastPc);
`else
        w_redirPc   = redirect_pc & ~32'h0000_0003;
        w_redirHigh = w_redirPc > LastPc;
`endif
    end

    // Sequencer state, fetch PC and FIFO storage; a redirect overrides any push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FETCH;
            r_fpc    <= PC_RESET;
            r_count  <= 2'd0;
            r_head   <= 1'b0;
            r_halted <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault  <= 1'b0;
`endif
            for (int i = 0; i < 2; i++) begin
                r_qPc[i]    <= '0;
                r_qInstr[i] <= '0;
            end
        end else if (w_redirect) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_redirBad) begin
                r_state  <= FAULT;
                r_halted <= 1'b1;
                r_fault  <= 1'b1;
            end else begin
                r_state  <= FETCH;
                r_fpc    <= redirect_pc;
                r_halted <= 1'b0;
            end
`else
            r_fpc <= w_redirPc;
            if (w_redirHigh) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
            end else begin
                r_state  <= FETCH;
                r_halted <= 1'b0;
            end
`endif
        end else begin
            r_count <= w_countNext;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_qPc[w_tail]    <= r_fpc;
                r_qInstr[w_tail] <= imem_instr;
                r_fpc            <= r_fpc + 32'd4;
            end
            case (r_state)
                FETCH: begin
                    if ((w_push && (r_fpc == LastPc)) || (r_fpc > LastPc)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_countNext == 2'd0) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Queue head presented to decode, zeroed whenever nothing is valid
    always_comb begin
        imem_pc   = r_fpc;
        out_valid = (r_count != 2'd0);
        out_pc    = out_valid ? r_qPc[r_head]    : 32'd0;
        out_instr = out_valid ? r_qInstr[r_head] : 32'd0;
        halted    = r_halted;
`ifdef FETCH_ALIGN_CHECK_EN
        fault     = r_fault;
`else
        fault     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer.
// The reference model is a list of fetched {pc, instr} entries plus a fetch PC and flags.
// Expected deliveries are queued when the handshake is offered.
// A negedge monitor compares them against the DUT.
module tb_fetch_sequencer;

    localparam logic [31:0] PcReset  = 32'h0000_0000;
    localparam int unsigned MemBytes = 32;
    localparam logic [31:0] LastPc   = 32'(MemBytes - 4);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        tbReady;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        tbRedirect;
    logic [31:0] tbRedirectPc;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;
    bit monEn  = 0;

    entry_t      mq[$];
    entry_t      sbQ[$];
    logic [31:0] mFpc;
    bit          mActive;
    bit          mHalted;
    bit          mFault;

    fetch_sequencer #(
        .PC_RESET (PcReset),
        .MEM_BYTES(MemBytes)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .out_valid  (out_valid),
        .out_ready  (tbReady),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .redirect   (tbRedirect),
        .redirect_pc(tbRedirectPc),
        .halted     (halted),
        .fault      (fault)
    );

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return {~pc[15:0], pc[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imem_instr = memWord(imem_pc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mq.delete();
        mFpc    = PcReset;
        mActive = 1'b1;
        mHalted = 1'b0;
        mFault  = 1'b0;
    endfunction

    // One rising edge of the abstract fetch model, using the inputs that were just sampled
    function automatic void modelEdge();
        bit          popNow;
        int          sizeBefore;
        logic [31:0] tgt;
        popNow     = tbReady && (mq.size() > 0);
        sizeBefore = mq.size();
        if (tbRedirect && !mFault) begin
            mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            if ((tbRedirectPc % 4) != 0 || tbRedirectPc > LastPc) begin
                mFault  = 1'b1;
                mHalted = 1'b1;
                mActive = 1'b0;
            end else begin
                mFpc    = tbRedirectPc;
                mActive = 1'b1;
                mHalted = 1'b0;
            end
`else
            tgt  = (tbRedirectPc / 4) * 4;
            mFpc = tgt;
            if (tgt > LastPc) begin
                mActive = 1'b0;
                mHalted = 1'b1;
            end else begin
                mActive = 1'b1;
                mHalted = 1'b0;
            end
`endif
        end else begin
            if (popNow) begin
                void'(mq.pop_front());
            end
            if (mActive && (sizeBefore < 2 || popNow)) begin
                mq.push_back('{pc: mFpc, instr: memWord(mFpc)});
                if (mFpc == LastPc) begin
                    mActive = 1'b0;
                end
                mFpc = mFpc + 32'd4;
            end
            if (!mActive && !mHalted && !mFault && mq.size() == 0) begin
                mHalted = 1'b1;
            end
        end
    endfunction

    // Drive one cycle of inputs, record any delivery decode will take, then advance the model
    task automatic applyStimulus(input bit rdy, input bit rd, input logic [31:0] rpc);
        tbReady      = rdy;
        tbRedirect   = rd;
        tbRedirectPc = rpc;
        if (rdy && mq.size() > 0) begin
            sbQ.push_back(mq[0]);
        end
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Asynchronous reset between clock edges; outputs must clear without any edge
    task automatic resetDut();
        monEn = 0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rstValid",  {31'd0, out_valid}, 32'd0);
        checkOutput("rstHalted", {31'd0, halted},    32'd0);
        checkOutput("rstFault",  {31'd0, fault},     32'd0);
        checkOutput("rstImemPc", imem_pc,            PcReset);
        checkOutput("rstOutPc",  out_pc,             32'd0);
        sbQ.delete();
        modelReset();
        tbReady    = 1'b0;
        tbRedirect = 1'b0;
        #2;
        rst   = 1'b1;
        monEn = 1;
    endtask

    // Monitor: per-cycle output comparison and scoreboard drain on each handshake
    always @(negedge clk) begin
        entry_t e;
        if (monEn) begin
            checkOutput("valid",  {31'd0, out_valid}, {31'd0, mq.size() > 0});
            checkOutput("halted", {31'd0, halted},    {31'd0, mHalted});
            checkOutput("fault",  {31'd0, fault},     {31'd0, mFault});
            checkOutput("imemPc", imem_pc,            mFpc);
            if (mq.size() > 0) begin
                checkOutput("headPc",    out_pc,    mq[0].pc);
                checkOutput("headInstr", out_instr, mq[0].instr);
            end else begin
                checkOutput("idlePc",    out_pc,    32'd0);
                checkOutput("idleInstr", out_instr, 32'd0);
            end
            if (out_valid && tbReady) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL handshake unexpected actual pc=%h expected none", out_pc);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("deliverPc",    out_pc,    e.pc);
                    checkOutput("deliverInstr", out_instr, e.instr);
                end
            end else if (sbQ.size() != 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake missing actual none expected pc=%h", sbQ[0].pc);
                sbQ.delete();
            end
        end
    end

    initial begin
        rst          = 1'b0;
        tbReady      = 1'b0;
        tbRedirect   = 1'b0;
        tbRedirectPc = 32'd0;
        modelReset();
        @(posedge clk);
        #1;
        resetDut();

        // Stream to the end of memory, halt, then restart by redirect
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Backpressure from reset, then release
        resetDut();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Redirect to 0x10 while the queue holds 4 and 8
        resetDut();
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Misaligned redirect target
        applyStimulus(1'b1, 1'b1, 32'h6);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Reset while the queue is full
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        resetDut();

        // Randomized traffic with occasional redirects, including illegal targets
        for (int i = 0; i < 800; i++) begin
            bit          rdy;
            bit          rd;
            logic [31:0] rpc;
            if (mFault && $urandom_range(0, 7) == 0) begin
                resetDut();
            end
            rdy = ($urandom_range(0, 9) < 7);
            rd  = mHalted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 40));
            applyStimulus(rdy, rd, rpc);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);

        monEn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller between the byte-addressed instruction memory and decode. Owns the fetch PC, drives the memory's PC input, captures the returned 32-bit word into a 2-entry fetch queue, and hands {pc, instruction} pairs to decode under a valid/ready handshake. Handles branch/jump redirects with a queue flush and stops cleanly at the end of instruction memory.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000: fetch PC loaded on reset; word-aligned.
- MEM_BYTES, 512: instruction memory size in bytes; multiple of 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- imem_pc  output  32  byte address to instruction memory; equals fetch PC.
- imem_instr  input  32  instruction word read combinationally at imem_pc.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  PC of head entry; 0 when out_valid=0.
- out_instr  output  32  instruction of head entry; 0 when out_valid=0.
- redirect  input  1  control-flow change request, single-cycle pulse.
- redirect_pc  input  32  new fetch target, valid with redirect.
- halted  output  1  fetch finished; queue empty, no further fetches.
- fault  output  1  illegal redirect target; sticky until reset.

## Operation
- States: FETCH, DRAIN, HALT, FAULT. Reset state FETCH.
- Reset values: fetch PC=PC_RESET, queue count=0, out_valid=0, out_pc=0, out_instr=0, halted=0, fault=0.
- pop = out_valid & out_ready. push allowed in FETCH when count<2, or count=2 with pop.
- On push: entry {fpc, imem_instr} written at tail; fpc += 4.
- Push with fpc = MEM_BYTES-4 is the last fetch; state -> DRAIN.
- DRAIN: no pushes; when count reaches 0 (including via a pop this cycle), state -> HALT.
- HALT: halted=1, imem_pc holds last fpc, no pushes.
- Queue is FIFO; head visible on out_* same cycle it is valid; out_* stable while out_valid & !out_ready.
- Redirect (any state except FAULT): queue flushed (count=0), fpc <= redirect_pc, state -> FETCH, halted cleared. Redirect has priority over same-cycle push and pop; a same-cycle pop is still treated as consumed by decode, the pushed word is discarded.
- Redirect target > MEM_BYTES-4 without the macro: state -> HALT next cycle (nothing fetched).
- FAULT: no pushes, queue empty, halted=1, fault=1; only reset exits.
- Arithmetic: fpc is 32-bit unsigned, wraps modulo 2^32 (unreachable under range rules).

## Timing
- First instruction: out_valid=1 on the first rising edge after rst deasserts; out_pc=PC_RESET.
- Throughput: one instruction per cycle with out_ready held high.
- Backpressure: with out_ready=0, queue fills in 2 cycles; fpc stalls at PC_RESET+8 (from reset).
- Redirect latency: out_valid=0 the cycle after the redirect edge; redirected instruction at out_* one cycle later (2 edges total).
- Asynchronous reset mid-operation: all state and outputs return to reset values immediately, independent of clk.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 or redirect_pc > MEM_BYTES-4 flushes queue, enters FAULT, asserts fault and halted next cycle.
- Not defined: redirect_pc[1:0] masked to 00; out-of-range target enters HALT; fault tied to 0.

## Test plan
- Reset release, out_ready=1 -> out_pc 0,4,8,12,16 on consecutive cycles with matching memory words; halted=0.
- out_ready=0 for 5 cycles after reset -> out_valid=1, out_pc=0 held stable, imem_pc=8; release -> out_pc 0,4,8 back-to-back.
- Redirect to 0x10 while queue holds PCs 4,8 -> out_valid=0 next cycle, then out_pc=0x10, 0x14.
- Run to end with MEM_BYTES=20 -> last out_pc=16, then halted=1, out_valid=0; redirect to 0 -> fetch resumes, halted=0.
- Redirect to 0x6: with FETCH_ALIGN_CHECK_EN -> fault=1, halted=1, no further out_valid; without -> out_pc=0x4.
- Assert rst mid-stream with count=2 -> out_valid, halted, fault immediately 0; imem_pc=PC_RESET.
